// File: rtl/zxesp_pkg.sv
// Shared types and constants for the ESP32-side UART receiver.
package zxesp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } zxesp_rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/zxesp_sync_fifo.sv
// First-word-fall-through synchronous FIFO; extra pointer bit separates full from empty.
module zxesp_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_peripheral,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_wr;
    logic                do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign level = wr_ptr - rd_ptr;

    // A pop frees the head slot in the same cycle, so a push into a full FIFO still lands.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk_peripheral or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_peripheral) begin
        if (do_wr) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end

endmodule

// File: rtl/zxesp32_uart_rx.sv
// 8N1 receiver for the ESP32 serial line: 16x oversampling, majority vote, FIFO-buffered stream out.
//   state | meaning
//   IDLE  | waiting for a falling edge on an armed line
//   START | checking the start bit at its centre
//   DATA  | shifting in data bits, LSB first
//   STOP  | checking the stop bit, then back to IDLE
module zxesp32_uart_rx
    import zxesp_pkg::*;
#(
    parameter int DATA_BITS       = 8,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int DIV_WIDTH       = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                       clk_peripheral,
    input  logic                       reset,
    input  logic                       uart_rx,
    input  logic                       enable,
    input  logic [DIV_WIDTH-1:0]       baud_div,
    output logic [DATA_BITS-1:0]       m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
    output logic                       frame_err,
    output logic                       break_det,
    output logic                       overrun,
    input  logic                       overrun_clr
);

    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [SCW-1:0] SAMP_A  = SCW'(MID_SAMPLE);
    localparam logic [SCW-1:0] SAMP_B  = SCW'(MID_SAMPLE + 1);
    localparam logic [SCW-1:0] VOTE_AT = SCW'(MID_SAMPLE + 2);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [DIV_WIDTH-1:0]   div_cnt;
    logic                   tick;
    zxesp_rx_state_t        state;
    logic [SCW-1:0]         samp_cnt;
    logic [BCW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   samp_a;
    logic                   samp_b;
    logic                   vote;
    logic                   armed;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_peripheral or posedge reset) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
    end

    assign tick = enable && (div_cnt == '0);

    always_ff @(posedge clk_peripheral or posedge reset) begin
        if (reset)         div_cnt <= '0;
        else if (tick)     div_cnt <= baud_div;
        else if (enable)   div_cnt <= div_cnt - 1'b1;
    end

    assign vote = majority3(samp_a, samp_b, rx_s);
    assign push = tick && (state == STOP) && (samp_cnt == VOTE_AT) && vote;

    // A failed stop bit disarms start detection until the line is seen high again,
    // so a held-low break produces a single error rather than a train of frames.
    always_ff @(posedge clk_peripheral or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            armed     <= 1'b0;
            frame_err <= 1'b0;
            break_det <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            break_det <= 1'b0;
            if (rx_s) armed <= 1'b1;
            if (!enable) begin
                state    <= IDLE;
                samp_cnt <= '0;
            end else if (state == IDLE) begin
                samp_cnt <= '0;
                if (!rx_s && armed) state <= START;
            end else if (tick) begin
                samp_cnt <= samp_cnt + 1'b1;
                if (samp_cnt == SAMP_A) samp_a <= rx_s;
                if (samp_cnt == SAMP_B) samp_b <= rx_s;
                if (samp_cnt == VOTE_AT) begin
                    case (state)
                        START: begin
                            if (vote) begin
                                state <= IDLE;
                            end else begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end
                        end
                        DATA: begin
                            shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                            if (bit_cnt == LAST_BIT) state <= STOP;
                            else                     bit_cnt <= bit_cnt + 1'b1;
                        end
                        STOP: begin
                            state <= IDLE;
                            if (!vote) begin
                                frame_err <= 1'b1;
                                break_det <= (shift_q == '0);
                                armed     <= 1'b0;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_peripheral or posedge reset) begin
        if (reset)                             overrun <= 1'b0;
        else if (push && fifo_full && !m_ready) overrun <= 1'b1;
        else if (overrun_clr)                  overrun <= 1'b0;
    end

    zxesp_sync_fifo #(
        .WIDTH      (DATA_BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk_peripheral (clk_peripheral),
        .reset          (reset),
        .wr_en          (push),
        .wr_data        (shift_q),
        .full           (fifo_full),
        .rd_en          (m_ready),
        .rd_data        (m_data),
        .empty          (fifo_empty),
        .level          (fifo_level)
    );

    assign m_valid = !fifo_empty;

endmodule
